// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter that grants one requester at a time write access to a
// shared WIDTH-bit register, bounding each ownership to MAX_HOLD captures under contention.
module dff_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   d_in,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [$clog2(N)-1:0] q_owner,
    output logic                 busy
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic [OW-1:0]    r_q_owner;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_ptr;
    logic [HW-1:0]    r_hold;
    logic             r_busy;

    logic             w_found;
    logic [OW-1:0]    w_sel;
    logic [N-1:0]     w_owner_mask;
    logic             w_owner_req;
    logic             w_others;
    logic [HW:0]      w_hold_inc;
    logic             w_last;
    logic [HW-1:0]    w_hold_next;
    logic [OW-1:0]    w_ptr_next;
    logic [WIDTH-1:0] w_slice;

    // First set request bit searching upward from the pointer, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && req[(32'(r_ptr) + i) % N]) begin
                w_found = 1'b1;
                w_sel   = OW'((32'(r_ptr) + i) % N);
            end
        end
    end

    always_comb begin
        w_owner_mask = N'(1) << r_owner;
        w_owner_req  = req[r_owner];
        w_others     = |(req & ~w_owner_mask);
        w_hold_inc   = {1'b0, r_hold} + (HW+1)'(1);
        // Saturated holders still yield on the next capture once someone else waits.
        w_last       = (w_hold_inc >= (HW+1)'(MAX_HOLD)) && w_others;
        w_hold_next  = (w_hold_inc > (HW+1)'(MAX_HOLD)) ? HW'(MAX_HOLD) : w_hold_inc[HW-1:0];
        w_ptr_next   = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);
        w_slice      = d_in[32'(r_owner)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_owner <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_q_valid <= 1'b0;
                    if (w_found) begin
                        r_gnt   <= N'(1) << w_sel;
                        r_owner <= w_sel;
                        r_hold  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_OWN;
                    end else begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                S_OWN: begin
                    if (w_owner_req) begin
                        r_q       <= w_slice;
                        r_q_owner <= r_owner;
                        r_q_valid <= 1'b1;
                        r_hold    <= w_hold_next;
                        if (w_last) begin
                            r_gnt   <= '0;
                            r_ptr   <= w_ptr_next;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_q_valid <= 1'b0;
                        r_gnt     <= '0;
                        r_ptr     <= w_ptr_next;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign q_owner = r_q_owner;
    assign busy    = r_busy;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
    a_gnt_in_own  : assert property (@(posedge clk) disable iff (rst)
                                     (r_gnt != '0) |-> (r_state == S_OWN && r_gnt[r_owner]));

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Directed-vector bench for dff_rr_arbiter (N=4, WIDTH=8, MAX_HOLD=4) with a
// behavioural reference model for the randomized phase.
module tb_dff_rr_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned BOUND    = (N - 1) * (MAX_HOLD + 1) + 1;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] d_in;
    logic [N-1:0]       gnt;
    logic [WIDTH-1:0]   q;
    logic               q_valid;
    logic [1:0]         q_owner;
    logic               busy;

    int n_vec;
    int n_err;

    // Reference model state
    bit         m_own;
    int         m_owner;
    int         m_ptr;
    int         m_hold;
    logic [3:0] m_gnt;
    logic [7:0] m_q;
    logic       m_qv;
    logic [1:0] m_qo;

    int wt[N];
    int max_wait;

    dff_rr_arbiter #(
        .N        (N),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d_in    (d_in),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_owner (q_owner),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_own = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        m_gnt = '0; m_q = '0; m_qv = 1'b0; m_qo = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_release();
        m_gnt = '0;
        m_ptr = (m_owner + 1) % N;
        m_own = 0;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [3:0] others;
        if (!m_own) begin
            m_qv = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!m_own && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_gnt   = 4'b0001 << m_owner;
                    m_hold  = 0;
                    m_own   = 1;
                end
            end
        end else if (req[m_owner]) begin
            m_q    = d_in[m_owner*WIDTH +: WIDTH];
            m_qo   = 2'(m_owner);
            m_qv   = 1'b1;
            others = req & ~(4'b0001 << m_owner);
            if (m_hold + 1 >= MAX_HOLD && others != 0) model_release();
            else m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
        end else begin
            m_qv = 1'b0;
            model_release();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = '0;
        d_in  = '0;

        // T1: reset state, then reset asserted mid-grant
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qv", 32'(q_valid), 32'h0);
        chk("rst_qo", 32'(q_owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst  = 1'b0;
        req  = 4'b0001;
        d_in = 32'h0000_0055;
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_qv0", 32'(q_valid), 32'h0);
        step();
        chk("t1_q", 32'(q), 32'h55);
        chk("t1_qv", 32'(q_valid), 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("t1_mid_gnt", 32'(gnt), 32'h0);
        chk("t1_mid_q", 32'(q), 32'h0);
        chk("t1_mid_qv", 32'(q_valid), 32'h0);
        chk("t1_mid_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("t1_regnt", 32'(gnt), 32'h1);
        chk("t1_regnt_q", 32'(q), 32'h0);

        // T2: lone requester holds ownership indefinitely
        do_reset();
        req  = 4'b0010;
        d_in = 32'h0000_A500;
        step();
        chk("t2_gnt", 32'(gnt), 32'h2);
        chk("t2_qv0", 32'(q_valid), 32'h0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t2_q", 32'(q), 32'hA5);
            chk("t2_qv", 32'(q_valid), 32'h1);
            chk("t2_qo", 32'(q_owner), 32'h1);
            chk("t2_gnt_hold", 32'(gnt), 32'h2);
        end
        req = '0;
        step();
        chk("t2_rel_gnt", 32'(gnt), 32'h0);
        chk("t2_rel_qv", 32'(q_valid), 32'h0);
        chk("t2_rel_q", 32'(q), 32'hA5);
        step();
        chk("t2_idle_busy", 32'(busy), 32'h0);

        // T3: all requesting, fair rotation with pointer wrap
        do_reset();
        req  = 4'b1111;
        d_in = 32'h1312_1110;
        step();
        chk("t3_gnt0", 32'(gnt), 32'h1);
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                chk("t3_q", 32'(q), 32'h10 + 32'(o % 4));
                chk("t3_qv", 32'(q_valid), 32'h1);
                chk("t3_qo", 32'(q_owner), 32'(o % 4));
                chk("t3_gnt", 32'(gnt), (c < 3) ? (32'h1 << (o % 4)) : 32'h0);
            end
            if (o < 4) begin
                step();
                chk("t3_bubble_qv", 32'(q_valid), 32'h0);
                chk("t3_next_gnt", 32'(gnt), 32'h1 << ((o + 1) % 4));
            end
        end

        // T4: voluntary release by owner 2, pointer wraps 3 -> 0
        do_reset();
        req = 4'b0100;
        step();
        chk("t4_gnt", 32'(gnt), 32'h4);
        req = 4'b0101;
        step();
        chk("t4_c1_q", 32'(q), 32'h12);
        chk("t4_c1_gnt", 32'(gnt), 32'h4);
        step();
        chk("t4_c2_q", 32'(q), 32'h12);
        chk("t4_c2_qo", 32'(q_owner), 32'h2);
        req = 4'b0001;
        step();
        chk("t4_rel_gnt", 32'(gnt), 32'h0);
        chk("t4_rel_qv", 32'(q_valid), 32'h0);
        chk("t4_rel_q", 32'(q), 32'h12);
        step();
        chk("t4_wrap_gnt", 32'(gnt), 32'h1);
        step();
        chk("t4_first_q", 32'(q), 32'h10);
        chk("t4_first_qo", 32'(q_owner), 32'h0);

        // T5: pointer at 3 favours index 3 over index 0
        do_reset();
        req = 4'b0100;
        step();
        step();
        req = 4'b1001;
        step();
        chk("t5_rel_gnt", 32'(gnt), 32'h0);
        step();
        chk("t5_gnt", 32'(gnt), 32'h8);
        step();
        chk("t5_q", 32'(q), 32'h13);
        chk("t5_qo", 32'(q_owner), 32'h3);

        // T6: random traffic against the reference model
        do_reset();
        max_wait = 0;
        for (int i = 0; i < N; i++) wt[i] = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            d_in = $urandom;
            model_step();
            step();
            chk("r_gnt", 32'(gnt), 32'(m_gnt));
            chk("r_qv", 32'(q_valid), 32'(m_qv));
            chk("r_busy", 32'(busy), 32'(m_own));
            if (m_qv) begin
                chk("r_q", 32'(q), 32'(m_q));
                chk("r_qo", 32'(q_owner), 32'(m_qo));
            end
            chk("r_onehot0", 32'($onehot0(gnt)), 32'h1);
            for (int i = 0; i < N; i++) begin
                if (req[i] && !gnt[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > max_wait) max_wait = wt[i];
            end
        end
        chk("r_max_wait_ok", 32'(max_wait <= BOUND), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
